// File: rtl/soc_inject_pkg.sv
// Shared definitions for the instruction-inject controller:
// Avalon register offsets and the CTRL/STATUS bit positions.
package soc_inject_pkg;

    // Avalon word offsets.
    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions.
    localparam int CTRL_HALT     = 0;
    localparam int CTRL_AUTO_INC = 1;
    localparam int CTRL_FLUSH    = 2;

    // STATUS bit positions (count occupies [7:0]).
    localparam int STAT_EMPTY    = 8;
    localparam int STAT_FULL     = 9;
    localparam int STAT_OVERFLOW = 10;
    localparam int STAT_HALT     = 11;

endpackage

// File: rtl/soc_inject_fifo.sv
// Show-ahead synchronous FIFO. The head entry is read straight out of
// registered storage, so o_rdata is valid in the same cycle o_empty drops.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_push, i_wdata      write request and entry
//   i_pop                consume head entry
//   i_flush              discard all entries (wins over push and pop)
//   o_rdata              head entry
//   o_count              fill level, 0..DEPTH
//   o_full, o_empty      fill flags
module soc_inject_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [W-1:0]     o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = CNT_W - 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // Full/empty are taken from pre-edge state, so a push into a full FIFO is
    // dropped even when a pop frees a slot in the same cycle.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Pointer and fill-count update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head fields read 0 while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/soc_ins_inject_ctrl.sv
// Avalon-MM slave that queues (address, instruction) pairs written by the host
// and drains them to the core's instruction-memory inject port over
// valid/ready. Also provides a core halt request, optional address
// auto-increment and fill/overflow status.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata                  Avalon-MM slave (zero wait state)
//   inj_valid, inj_ready,
//   inj_addr, inj_data                   inject stream towards the core
//   inj_halt                             core halt request
module soc_ins_inject_ctrl
    import soc_inject_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              inj_valid,
    input  logic              inj_ready,
    output logic [ADDR_W-1:0] inj_addr,
    output logic [DATA_W-1:0] inj_data,
    output logic              inj_halt
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int FIFO_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] r_addr;
    logic              r_halt;
    logic              r_auto_inc;
    logic              r_overflow;

    logic              w_wr;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic [FIFO_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    assign w_wr    = chipselect & ~write_n;
    assign w_push  = w_wr & (address == REG_DATA);
    assign w_flush = w_wr & (address == REG_CTRL) & writedata[CTRL_FLUSH];
    assign w_pop   = inj_valid & inj_ready;

    soc_inject_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_wdata ({r_addr, writedata[DATA_W-1:0]}),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign inj_valid = ~w_empty;
    assign inj_addr  = w_head[FIFO_W-1:DATA_W];
    assign inj_data  = w_head[DATA_W-1:0];
    assign inj_halt  = r_halt;

    // ADDR register: host write, or post-increment on an accepted push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= {ADDR_W{1'b0}};
        end else if (w_wr && (address == REG_ADDR)) begin
            r_addr <= writedata[ADDR_W-1:0];
        end else if (w_push && !w_full && r_auto_inc) begin
            r_addr <= r_addr + ADDR_W'(1'b1);
        end
    end

    // CTRL register; flush is a pulse and is not stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_halt     <= 1'b0;
            r_auto_inc <= 1'b0;
        end else if (w_wr && (address == REG_CTRL)) begin
            r_halt     <= writedata[CTRL_HALT];
            r_auto_inc <= writedata[CTRL_AUTO_INC];
        end
    end

    // Sticky overflow: set by a push into a full FIFO, cleared by writing 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_wr && (address == REG_STATUS) && writedata[STAT_OVERFLOW]) begin
            r_overflow <= 1'b0;
        end
    end

    // Read mux; combinational with no side effects, unused bits read 0.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            REG_ADDR: begin
                readdata[ADDR_W-1:0] = r_addr;
            end
            REG_CTRL: begin
                readdata[CTRL_HALT]     = r_halt;
                readdata[CTRL_AUTO_INC] = r_auto_inc;
            end
            REG_STATUS: begin
                readdata[7:0]           = 8'(w_count);
                readdata[STAT_EMPTY]    = w_empty;
                readdata[STAT_FULL]     = w_full;
                readdata[STAT_OVERFLOW] = r_overflow;
                readdata[STAT_HALT]     = r_halt;
            end
            default: begin
                readdata = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: tb/tb_soc_ins_inject_ctrl.sv
module tb_soc_ins_inject_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        inj_valid;
    logic        inj_ready;
    logic [9:0]  inj_addr;
    logic [31:0] inj_data;
    logic        inj_halt;

    int checks;
    int errors;

    soc_ins_inject_ctrl #(
        .ADDR_W (10),
        .DATA_W (32),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .inj_valid  (inj_valid),
        .inj_ready  (inj_ready),
        .inj_addr   (inj_addr),
        .inj_data   (inj_data),
        .inj_halt   (inj_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        chk(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    // Check the head entry, then accept it for one cycle.
    task automatic pop_chk(input logic [9:0] ea, input logic [31:0] ed, input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, inj_valid}, 32'd1);
        chk({tag, "_addr"}, {22'd0, inj_addr}, {22'd0, ea});
        chk({tag, "_data"}, inj_data, ed);
        inj_ready = 1'b1;
        @(posedge clk);
        #1;
        inj_ready = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        inj_ready  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 1: reset state
        rd(2'd0, 32'h0000_0000, "rst_addr");
        rd(2'd1, 32'h0000_0000, "rst_data");
        rd(2'd2, 32'h0000_0000, "rst_ctrl");
        rd(2'd3, 32'h0000_0100, "rst_status");
        chk("rst_valid", {31'd0, inj_valid}, 32'd0);
        chk("rst_halt", {31'd0, inj_halt}, 32'd0);
        chk("rst_inj_addr", {22'd0, inj_addr}, 32'd0);
        chk("rst_inj_data", inj_data, 32'd0);

        // 2: auto-increment with address wrap
        wr(2'd2, 32'h0000_0002);
        wr(2'd0, 32'h0000_03FE);
        wr(2'd1, 32'h0000_000A);
        chk("lat_valid", {31'd0, inj_valid}, 32'd1);
        chk("lat_addr", {22'd0, inj_addr}, 32'h0000_03FE);
        chk("lat_data", inj_data, 32'h0000_000A);
        wr(2'd1, 32'h0000_000B);
        wr(2'd1, 32'h0000_000C);
        rd(2'd0, 32'h0000_0001, "wrap_addr");
        rd(2'd3, 32'h0000_0003, "q3_status");
        rd(2'd1, 32'h0000_0000, "data_reads0");
        rd(2'd2, 32'h0000_0002, "ctrl_autoinc");
        pop_chk(10'h3FE, 32'h0000_000A, "h0");
        pop_chk(10'h3FF, 32'h0000_000B, "h1");
        pop_chk(10'h000, 32'h0000_000C, "h2");
        chk("drained_valid", {31'd0, inj_valid}, 32'd0);
        rd(2'd3, 32'h0000_0100, "drained_status");

        // 3: overflow, ADDR frozen on the dropped push, clear by W1C
        for (int i = 1; i <= 5; i++) begin
            wr(2'd1, 32'(i));
        end
        rd(2'd3, 32'h0000_0604, "ovf_status");
        rd(2'd0, 32'h0000_0005, "ovf_addr");
        wr(2'd3, 32'h0000_0400);
        rd(2'd3, 32'h0000_0204, "ovf_clear");
        for (int i = 1; i <= 4; i++) begin
            pop_chk(10'(i), 32'(i), "ovf_drain");
        end
        chk("ovf_nofifth", {31'd0, inj_valid}, 32'd0);

        // 4: simultaneous push and pop keeps count
        wr(2'd1, 32'h0000_0021);
        wr(2'd1, 32'h0000_0022);
        @(negedge clk);
        inj_ready  = 1'b1;
        address    = 2'd1;
        writedata  = 32'h0000_0023;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        inj_ready  = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("pp_valid", {31'd0, inj_valid}, 32'd1);
        rd(2'd3, 32'h0000_0002, "pp_status");
        pop_chk(10'h006, 32'h0000_0022, "pp_h0");
        pop_chk(10'h007, 32'h0000_0023, "pp_h1");
        chk("pp_empty", {31'd0, inj_valid}, 32'd0);

        // Full with a same-cycle pop: push is still dropped
        for (int i = 1; i <= 4; i++) begin
            wr(2'd1, 32'h0000_0030 + 32'(i));
        end
        @(negedge clk);
        inj_ready  = 1'b1;
        address    = 2'd1;
        writedata  = 32'h0000_0035;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        inj_ready  = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(2'd3, 32'h0000_0403, "fullpop_status");
        rd(2'd0, 32'h0000_000C, "fullpop_addr");
        wr(2'd3, 32'h0000_0400);
        rd(2'd3, 32'h0000_0003, "fullpop_clear");

        // 5: flush with halt
        wr(2'd2, 32'h0000_0005);
        chk("fl_valid", {31'd0, inj_valid}, 32'd0);
        chk("fl_halt", {31'd0, inj_halt}, 32'd1);
        rd(2'd3, 32'h0000_0900, "fl_status");
        rd(2'd2, 32'h0000_0001, "fl_ctrl");

        // Entries drain while halted; auto-increment now off
        wr(2'd1, 32'h0000_0041);
        wr(2'd1, 32'h0000_0042);
        pop_chk(10'h00C, 32'h0000_0041, "halt_drain");

        // 6: asynchronous reset mid-drain
        @(negedge clk);
        inj_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, inj_valid}, 32'd0);
        chk("arst_halt", {31'd0, inj_halt}, 32'd0);
        chk("arst_inj_data", inj_data, 32'd0);
        inj_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, 32'h0000_0000, "post_addr");
        rd(2'd2, 32'h0000_0000, "post_ctrl");
        rd(2'd3, 32'h0000_0100, "post_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
